// File: rtl/dlatch_pkg.sv
// Shared helpers for the latch primitives and dlatch_queue: pointer wrap and width helpers.
// The optional DLATCH_QUEUE_BYPASS_EN build uses nothing extra from here.
package dlatch_pkg;

    localparam int unsigned DLATCH_DEFAULT_DEPTH = 4;

    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int unsigned lvl_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dlatch_queue_ctrl.sv
// Pointer, occupancy and handshake control for dlatch_queue.
// DLATCH_QUEUE_BYPASS_EN lets an empty queue present its input word in the same cycle.
module dlatch_queue_ctrl
    import dlatch_pkg::*;
#(
    parameter int unsigned DEPTH = DLATCH_DEFAULT_DEPTH,
    parameter int unsigned PW    = ptr_w(DEPTH),
    parameter int unsigned LW    = lvl_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          out_ready,
    output logic          in_ready,
    output logic          out_valid,
    output logic          push,
    output logic          pop,
    output logic          bypass,
    output logic [PW-1:0] wptr,
    output logic [PW-1:0] rptr,
    output logic [LW-1:0] level
);

    always_comb begin
        bypass = 1'b0;
`ifdef DLATCH_QUEUE_BYPASS_EN
        bypass = (level == '0) && in_valid;
`endif
        in_ready  = (level != LW'(DEPTH));
        out_valid = (level != '0) || bypass;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // A consumed bypass word counts as push and pop together, so the pointers stay equal.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push)
                wptr <= PW'(ptr_inc(32'(wptr), DEPTH));
            if (pop)
                rptr <= PW'(ptr_inc(32'(rptr), DEPTH));
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/dlatch_queue.sv
// Multi-entry latch queue: circular buffer whose output holds the last popped word when empty.
// Define DLATCH_QUEUE_BYPASS_EN to pass d straight to o when the queue is empty.
module dlatch_queue
    import dlatch_pkg::*;
#(
    parameter int unsigned N     = 1,
    parameter int unsigned DEPTH = DLATCH_DEFAULT_DEPTH,
    parameter logic [N-1:0] RVAL = {N{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             d,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [N-1:0]             o,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [lvl_w(DEPTH)-1:0]  level
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned LW = lvl_w(DEPTH);

    logic [N-1:0]  mem [DEPTH];
    logic [N-1:0]  hold;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          push;
    logic          pop;
    logic          bypass;

    dlatch_queue_ctrl #(
        .DEPTH (DEPTH),
        .PW    (PW),
        .LW    (LW)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .push      (push),
        .pop       (pop),
        .bypass    (bypass),
        .wptr      (wptr),
        .rptr      (rptr),
        .level     (level)
    );

    always_comb begin
        if (bypass)
            o = d;
        else if (level != '0)
            o = mem[rptr];
        else
            o = hold;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold <= RVAL;
            for (int i = 0; i < int'(DEPTH); i++)
                mem[i] <= RVAL;
        end else begin
            if (push)
                mem[wptr] <= d;
            if (pop)
                hold <= o;
        end
    end

endmodule

// File: doc/dlatch_queue.md
# dlatch_queue

Parametrised successor to the single-entry LUT D-latch. It holds up to DEPTH words of N bits in a clocked circular buffer with valid/ready handshakes on both sides and an occupancy count. The output holds the last word delivered, as a latch does, so downstream logic never sees undefined data when the queue is empty. It sits between asynchronous-domain capture logic and clocked consumers wherever more than one word of slack is needed.

## Interface
- N, 1: data width in bits (≥1)
- DEPTH, 4: number of storage entries (≥2, any integer, not restricted to powers of two)
- RVAL, {N{1'b0}}: per-bit reset value of the storage entries and of `o`
- clk  input  1  clock
- rst  input  1  reset; synchronous and active-high (polarity and synchronicity fixed)
- d  input  N  write data
- in_valid  input  1  write request
- in_ready  output  1  queue can accept; high when level < DEPTH
- o  output  N  head data; holds the last popped word when the queue is empty
- out_valid  output  1  `o` carries a not-yet-consumed word
- out_ready  input  1  consumer accepts `o`
- level  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH

## Operation
- Push: in_valid & in_ready. Write `d` to the entry at `wptr`. `wptr` advances and wraps from DEPTH-1 to 0.
- Pop: out_valid & out_ready. `rptr` advances with the same wrap rule. `hold` is loaded with the popped word.
- Output mux:
  - level > 0: `o` = entry[rptr].
  - level = 0: `o` = `hold` (latch semantics).
- `out_valid` = (level > 0).
- Level update, all in the same clock edge:
  - +1 on push only.
  - −1 on pop only.
  - unchanged on simultaneous push and pop.
- Full (level = DEPTH): in_ready = 0. A push is ignored even if a pop occurs in the same cycle; there is no full pass-through.
- Empty (level = 0): out_valid = 0. out_ready is ignored.
- Reset, including mid-operation:
  - level, wptr and rptr go to 0.
  - hold and every entry go to RVAL.
  - Any push or pop in the reset cycle is discarded.
- Outputs during and after reset: o = RVAL, out_valid = 0, in_ready = 1, level = 0.
- Internal state: wptr, rptr (width $clog2(DEPTH)), level counter, hold register.

## Timing
- Every output is a function of registered state. The one exception is the bypass path under DLATCH_QUEUE_BYPASS_EN.
- Write latency: a word pushed at edge t is visible on `o` with out_valid = 1 after edge t (cycle t+1).
- Throughput: one push and one pop per cycle when 0 < level < DEPTH.
- in_ready does not depend on out_ready, so there is no combinational ready path from consumer to producer.

## Configuration
- Macro: DLATCH_QUEUE_BYPASS_EN.
- Defined: when level = 0 and in_valid = 1:
  - o = d and out_valid = 1 combinationally.
  - If out_ready = 1 in that cycle, the word is consumed without being stored: level stays 0, hold loads `d`, and wptr and rptr both advance so they stay equal.
  - If out_ready = 0, the word is stored normally.
- Not defined: no path from in_valid or d to the outputs. Minimum latency is 1 cycle.

## Structure
- Package dlatch_pkg holds:
  - function `ptr_inc(ptr, DEPTH)`, the wrap increment.
  - localparam helpers for pointer and level widths.
  - shared by the existing latch primitives and this block.
- Sub-module: dlatch_queue_ctrl, holding the pointers, level counter, and ready/valid logic.
- Storage array and output mux stay in the top module.

## Test plan
- Reset value: RVAL=8'hA5, N=8. Assert rst for 2 cycles → o=8'hA5, level=0, out_valid=0, in_ready=1.
- Fill and drain: DEPTH=4. Push 1,2,3,4 with out_ready=0 → level=4, in_ready=0, 5th push ignored. Then out_ready=1 → o reads 1,2,3,4 in order. After the drain, o holds 4 and out_valid=0.
- Wrap and simultaneous: DEPTH=3, level=2. Push and pop every cycle for 10 cycles → level stays 2, data emerges in FIFO order across the pointer wrap.
- Full plus pop: level=DEPTH with in_valid=1 and out_ready=1 → level becomes DEPTH−1 and the pushed word is dropped (in_ready was 0).
- Reset mid-operation: level=3, then rst=1 together with in_valid=1 → next cycle level=0, o=RVAL, the pushed word is absent.
- Bypass (macro defined): empty queue, d=8'h3C, in_valid=1, out_ready=1 → same cycle o=8'h3C and out_valid=1. Next cycle level=0 and o holds 8'h3C.
